pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator and successor to the single-channel PWM block. It drives NUM_CH outputs from one shared CW-bit period counter and supports edge-aligned and center-aligned modes. Each channel has its own duty value and polarity. Period, mode and duty are double-buffered and take effect only at period boundaries, so outputs are glitch-free. The block sits between the register/control logic and the gate-drive or LED pins.

---
 rtl/pwm_multi_if.sv | 17 +
 rtl/pwm_multi.sv | 144 ++++++++++++++
 tb/tb_pwm_multi.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// Duty-programming bus for pwm_multi: direct writes plus saturating +/-1 steps.
// The master side is the register/control logic; the PWM block is the slave.
interface pwm_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CW     = 16,
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_duty;
    logic           inc;
    logic           dec;
    logic [CHW-1:0] step_ch;

    modport master (output wr_en, wr_ch, wr_duty, inc, dec, step_ch);
    modport slave  (input  wr_en, wr_ch, wr_duty, inc, dec, step_ch);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared edge/center-aligned counter. Period, mode and
// duty are double-buffered and only take effect on a load (idle or period end).
module pwm_multi #(
    parameter int NUM_CH = 4,
    parameter int CW     = 16,
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              center_mode,
    input  logic [CW-1:0]     period,
    pwm_multi_if.slave        duty_bus,
    input  logic [NUM_CH-1:0] polarity,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic [CW-1:0]     cnt
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    logic [CW-1:0]     cnt_q, cnt_d;
    dir_e              dir_q, dir_d;
    logic [CW-1:0]     act_period_q;
    logic              act_mode_q;
    logic [CW-1:0]     act_duty_q    [NUM_CH];
    logic [CW-1:0]     shadow_duty_q [NUM_CH];
    logic [CW-1:0]     shadow_duty_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] raw_s;
    logic              running_s;
    logic              term_s;
    logic              load_s;

    // Shadow duty update; an out-of-range index simply matches no channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_duty_d[i] = shadow_duty_q[i];
            if (duty_bus.wr_en && (int'(duty_bus.wr_ch) == i)) begin
                shadow_duty_d[i] = duty_bus.wr_duty;
            end else if ((int'(duty_bus.step_ch) == i) && duty_bus.inc && !duty_bus.dec
                         && (shadow_duty_q[i] != {CW{1'b1}})) begin
                shadow_duty_d[i] = shadow_duty_q[i] + CW'(1);
            end else if ((int'(duty_bus.step_ch) == i) && duty_bus.dec && !duty_bus.inc
                         && (shadow_duty_q[i] != {CW{1'b0}})) begin
                shadow_duty_d[i] = shadow_duty_q[i] - CW'(1);
            end else begin
                shadow_duty_d[i] = shadow_duty_q[i];
            end
        end
    end

    // Terminal-cycle detection for the active period and mode.
    always_comb begin
        running_s = enable && (act_period_q != {CW{1'b0}});
        if (act_mode_q) begin
            term_s = (dir_q == DIR_DOWN) && (cnt_q == CW'(1));
        end else begin
            term_s = (cnt_q == (act_period_q - CW'(1)));
        end
        load_s = !running_s || term_s;
    end

    // Counter/direction next state: restart on load, else count per mode.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load_s) begin
            cnt_d = {CW{1'b0}};
            dir_d = DIR_UP;
        end else if (!act_mode_q) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            case (dir_q)
                DIR_UP: begin
                    cnt_d = cnt_q + CW'(1);
                    if ((cnt_q + CW'(1)) == act_period_q) begin
                        dir_d = DIR_DOWN;
                    end else begin
                        dir_d = DIR_UP;
                    end
                end
                DIR_DOWN: begin
                    cnt_d = cnt_q - CW'(1);
                    dir_d = DIR_DOWN;
                end
                default: begin
                    cnt_d = {CW{1'b0}};
                    dir_d = DIR_UP;
                end
            endcase
        end
    end

    // Per-channel compare; the down phase uses <= so center-mode pulses stay symmetric.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (dir_q == DIR_UP) begin
                raw_s[i] = (cnt_q < act_duty_q[i]);
            end else begin
                raw_s[i] = (cnt_q <= act_duty_q[i]);
            end
            if (running_s) begin
                pwm_d[i] = raw_s[i] ^ polarity[i];
            end else begin
                pwm_d[i] = polarity[i];
            end
        end
    end

    // State registers; active copies capture the pre-update shadow on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= {CW{1'b0}};
            dir_q        <= DIR_UP;
            act_period_q <= {CW{1'b0}};
            act_mode_q   <= 1'b0;
            pwm_q        <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                act_duty_q[i]    <= {CW{1'b0}};
                shadow_duty_q[i] <= {CW{1'b0}};
            end
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty_q[i] <= shadow_duty_d[i];
            end
            if (load_s) begin
                act_period_q <= period;
                act_mode_q   <= center_mode;
                for (int i = 0; i < NUM_CH; i++) begin
                    act_duty_q[i] <= shadow_duty_q[i];
                end
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign cnt          = cnt_q;
    assign period_start = running_s && (cnt_q == {CW{1'b0}}) && (dir_q == DIR_UP);

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (NUM_CH=4, CW=16).
module tb_pwm_multi;

    localparam int NUM_CH = 4;
    localparam int CW     = 16;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              center_mode;
    logic [CW-1:0]     period;
    logic [NUM_CH-1:0] polarity;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;
    logic [CW-1:0]     cnt;

    int n_checks = 0;
    int n_errors = 0;

    pwm_multi_if #(.NUM_CH(NUM_CH), .CW(CW)) duty_bus ();

    pwm_multi #(.NUM_CH(NUM_CH), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .center_mode  (center_mode),
        .period       (period),
        .duty_bus     (duty_bus),
        .polarity     (polarity),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .cnt          (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Called at a falling edge; holds the write for one rising edge.
    task automatic write_duty(input int ch, input int val);
        duty_bus.wr_en   = 1'b1;
        duty_bus.wr_ch   = 2'(ch);
        duty_bus.wr_duty = 16'(val);
        @(negedge clk);
        duty_bus.wr_en   = 1'b0;
    endtask

    initial begin
        int hi_a;
        int hi_b;
        int ps_n;
        int k;
        int kp;
        int c;
        logic up;
        logic [3:0] exp_pwm;

        reset = 1'b1; enable = 1'b0; center_mode = 1'b0; period = 16'd0; polarity = 4'b0000;
        duty_bus.wr_en = 1'b0; duty_bus.wr_ch = 2'd0; duty_bus.wr_duty = 16'd0;
        duty_bus.inc = 1'b0; duty_bus.dec = 1'b0; duty_bus.step_ch = 2'd0;
        #1;
        check_eq("reset_pwm", 32'(pwm_out), 32'd0);
        check_eq("reset_cnt", 32'(cnt), 32'd0);
        check_eq("reset_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Edge mode: P=10, D = 3,0,10,15
        period = 16'd10;
        write_duty(0, 3); write_duty(1, 0); write_duty(2, 10); write_duty(3, 15);
        @(negedge clk);
        enable = 1'b1;
        #1;
        ps_n = 0;
        for (int j = 0; j <= 20; j++) begin
            if (j > 0) @(negedge clk);
            check_eq("edge_cnt", 32'(cnt), 32'(j % 10));
            if (j > 0) begin
                exp_pwm = {1'b1, 1'b1, 1'b0, (((j - 1) % 10) < 3)};
                check_eq("edge_pwm", 32'(pwm_out), 32'(exp_pwm));
            end
            if (j < 20) ps_n += int'(period_start);
        end
        check_eq("edge_ps_count", 32'(ps_n), 32'd2);

        // Center mode: P=8, D0=3
        enable = 1'b0; period = 16'd8; center_mode = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        #1;
        ps_n = 0; hi_a = 0;
        for (int j = 0; j <= 32; j++) begin
            if (j > 0) @(negedge clk);
            k = j % 16;
            check_eq("ctr_cnt", 32'(cnt), 32'((k <= 8) ? k : 16 - k));
            if (j > 0) begin
                kp = (j - 1) % 16;
                c  = (kp <= 8) ? kp : 16 - kp;
                up = (kp < 8);
                exp_pwm = {1'b1, 1'b1, 1'b0, (up ? (c < 3) : (c <= 3))};
                check_eq("ctr_pwm", 32'(pwm_out), 32'(exp_pwm));
                if (j <= 16) hi_a += int'(pwm_out[0]);
            end
            if (j < 32) ps_n += int'(period_start);
        end
        check_eq("ctr_ch0_high", 32'(hi_a), 32'd6);
        check_eq("ctr_ps_count", 32'(ps_n), 32'd2);

        // Double buffering: D0 10->2 at cnt=4, P 20->5 at cnt=12
        enable = 1'b0; center_mode = 1'b0; period = 16'd20;
        write_duty(0, 10);
        @(negedge clk);
        enable = 1'b1;
        #1;
        hi_a = 0; hi_b = 0;
        for (int j = 0; j <= 30; j++) begin
            if (j > 0) @(negedge clk);
            check_eq("dbuf_cnt", 32'(cnt), 32'((j < 20) ? j : (j - 20) % 5));
            if (j == 20 || j == 25) check_eq("dbuf_ps", 32'(period_start), 32'd1);
            if (j >= 1 && j <= 20) hi_a += int'(pwm_out[0]);
            if (j >= 21) hi_b += int'(pwm_out[0]);
            if (j == 4) begin
                duty_bus.wr_en = 1'b1; duty_bus.wr_ch = 2'd0; duty_bus.wr_duty = 16'd2;
            end
            if (j == 5) duty_bus.wr_en = 1'b0;
            if (j == 12) period = 16'd5;
        end
        check_eq("dbuf_old_high", 32'(hi_a), 32'd10);
        check_eq("dbuf_new_high", 32'(hi_b), 32'd4);

        // Step saturation and write/step priority
        write_duty(1, 65534);
        duty_bus.step_ch = 2'd1; duty_bus.inc = 1'b1;
        repeat (3) @(negedge clk);
        duty_bus.inc = 1'b0;
        check_eq("sat_inc", 32'(dut.shadow_duty_q[1]), 32'd65535);
        duty_bus.inc = 1'b1; duty_bus.dec = 1'b1;
        @(negedge clk);
        duty_bus.inc = 1'b0; duty_bus.dec = 1'b0;
        check_eq("inc_dec_hold", 32'(dut.shadow_duty_q[1]), 32'd65535);
        duty_bus.dec = 1'b1;
        write_duty(1, 100);
        duty_bus.dec = 1'b0;
        check_eq("wr_beats_dec", 32'(dut.shadow_duty_q[1]), 32'd100);
        write_duty(1, 0);
        duty_bus.dec = 1'b1;
        @(negedge clk);
        duty_bus.dec = 1'b0;
        check_eq("sat_dec", 32'(dut.shadow_duty_q[1]), 32'd0);
        duty_bus.step_ch = 2'd2; duty_bus.dec = 1'b1;
        write_duty(1, 7);
        duty_bus.dec = 1'b0;
        check_eq("wr_other_ch", 32'(dut.shadow_duty_q[1]), 32'd7);
        check_eq("dec_other_ch", 32'(dut.shadow_duty_q[2]), 32'd9);

        // Polarity and enable
        enable = 1'b0; polarity = 4'b0101;
        @(negedge clk);
        check_eq("idle_pwm", 32'(pwm_out), 32'b0101);
        check_eq("idle_cnt", 32'(cnt), 32'd0);
        check_eq("idle_ps", 32'(period_start), 32'd0);
        enable = 1'b1;
        #1;
        check_eq("en_ps", 32'(period_start), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("run_cnt", 32'(cnt), 32'd3);
        enable = 1'b0;
        @(negedge clk);
        check_eq("dis_cnt", 32'(cnt), 32'd0);
        check_eq("dis_pwm", 32'(pwm_out), 32'b0101);
        enable = 1'b1;
        #1;
        check_eq("reen_ps", 32'(period_start), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("reen_cnt", 32'(cnt), 32'd3);

        // Async reset between edges, then restart with a same-cycle duty write
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_pwm", 32'(pwm_out), 32'd0);
        check_eq("arst_cnt", 32'(cnt), 32'd0);
        check_eq("arst_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        check_eq("arst_hold_pwm", 32'(pwm_out), 32'd0);
        reset = 1'b0;
        duty_bus.wr_en = 1'b1; duty_bus.wr_ch = 2'd0; duty_bus.wr_duty = 16'd2;
        #1;
        check_eq("rel_ps", 32'(period_start), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            duty_bus.wr_en = 1'b0;
            check_eq("rel_cnt", 32'(cnt), 32'((i - 1) % 5));
            exp_pwm = (i == 7 || i == 8) ? 4'b0100 : 4'b0101;
            check_eq("rel_pwm", 32'(pwm_out), 32'(exp_pwm));
            if (i == 1 || i == 6) check_eq("rel_ps_start", 32'(period_start), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
